exp_taylor: RTL and testbench
=============================

Name: exp_taylor

Overview:
- Computes e^x for a signed fixed-point argument using a Horner-form Taylor series centred at 0: y = 1 + x/1·(1 + x/2·(1 + … (1 + x/N))).
- Inverse companion of the pipelined ln(x) block; it converts log-domain HSS quantities back to the linear domain.
- Iterative single-MAC datapath, one term per clock, with valid/ready handshakes on both sides.
- Uses the same 32-bit signed fixed-point format as the rest of the HSS datapath; fraction width comes from `H_FXP_DECIMAL_BITS in system_defines.vh.

Parameters:
N_TERMS, 8, number of series terms (Horner iterations); legal range 1..15.
FRAC_BITS, `H_FXP_DECIMAL_BITS (10), fractional bits of in_data/out_data; ONE = 1 << FRAC_BITS.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous reset, active-high.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept an argument.
in_data  input  32  signed x, FRAC_BITS fraction bits.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts out_data.
out_data  output  32  signed e^x, FRAC_BITS fraction bits.
busy  output  1  high while state != IDLE.

Behaviour:
- Interface (already decided): one clock, CLK. RST is asynchronous and active-high; it applies immediately, regardless of CLK.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
  - Internal x_reg = 0, acc = 0, k = 0.
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state == IDLE); busy = (state != IDLE). Both are combinational from state.
- IDLE:
  - On an edge with in_valid = 1: x_reg <= in_data, acc <= ONE, k <= N_TERMS, state -> CALC.
  - Otherwise remain in IDLE.
- CALC, one iteration per edge:
  - p = (acc * x_reg) as a 64-bit signed product.
  - t = p >>> FRAC_BITS (arithmetic shift, floor), truncated to 32 bits.
  - acc <= ONE + (t / k). Signed integer division truncates toward zero.
  - k <= k - 1.
  - When k == 1 on the current edge: out_data <= ONE + t, state -> DONE, out_valid <= 1.
- DONE:
  - out_data and out_valid are held stable until out_ready = 1.
  - On an edge with out_valid = 1 and out_ready = 1: out_valid <= 0, state -> IDLE.
  - out_data keeps its last value after the handshake; it is not cleared.
- Latency and throughput:
  - Argument accepted at edge 0; out_valid rises after edge N_TERMS.
  - Minimum issue interval is N_TERMS + 2 cycles. in_ready is low from edge 0 until the cycle after the output handshake.
- Arithmetic:
  - No saturation; acc wraps to 32 bits.
  - Specified input range is −8.0 ≤ x ≤ 8.0. Results outside that range are undefined but must not hang the FSM.
- Boundary conditions:
  - in_valid while busy: ignored; the argument is not captured and in_ready stays 0.
  - out_ready held high before out_valid: no effect until DONE.
  - out_ready = 1 in the same cycle out_valid first rises: handshake completes on the next edge (1-cycle DONE).
  - RST mid-CALC or mid-DONE: aborts immediately. out_valid drops asynchronously and the block returns to reset values; no partial result is emitted.
  - N_TERMS = 1: the single CALC cycle yields ONE + x.
  - x = 0: every t = 0, so the result is ONE exactly.

Test Plan:
1. Reset, then in_data = 32'd1024 (1.0), N_TERMS = 8 → out_valid after edge 8; out_data = 2783 (0xADF); in_ready low throughout and high again one cycle after the output handshake.
2. in_data = −1024 (−1.0) → out_data = 377. in_data = 512 (0.5) → out_data = 1688. in_data = 0 → out_data = 1024.
3. Back-pressure: out_ready held 0 for 5 cycles after out_valid → out_data stays 2783 and out_valid stays 1. A second in_valid pulse in that window is ignored; the next accepted argument produces the correct result.
4. Asynchronous RST pulse between edges during CALC iteration 4 → outputs immediately return to reset values (out_valid = 0, out_data = 0, in_ready = 1) without waiting for a clock edge; the next argument 1024 still yields 2783.
5. Back-to-back streaming with in_valid and out_ready tied high, args 1024 / −1024 / 512 → results 2783 / 377 / 1688 in order, each 10 cycles apart.
6. Parameter sweep N_TERMS = 1 with x = 1024 → out_data = 2048, out_valid after edge 1.

Source files
------------

// File: rtl/exp_taylor.sv
// exp_taylor: iterative e^x for a signed fixed-point argument.
//
// Evaluates the Taylor series about 0 in Horner form,
//   y = 1 + x/1*(1 + x/2*(1 + ... (1 + x/N))),
// one term per clock on a single multiply/divide datapath. Companion of the
// ln(x) block: maps log-domain quantities back to the linear domain.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-high
//   in_valid   in_data valid
//   in_ready   block can accept an argument (state == IDLE)
//   in_data    signed x, FRAC_BITS fraction bits
//   out_valid  out_data valid, held until out_ready
//   out_ready  consumer accepts out_data
//   out_data   signed e^x, FRAC_BITS fraction bits (kept after handshake)
//   busy       high while a computation or result is pending
//
// States:
//   IDLE | waiting for an argument, in_ready high
//   CALC | one Horner iteration per clock, k counts down N_TERMS..1
//   DONE | result presented, waiting for out_ready

`ifndef H_FXP_DECIMAL_BITS
`define H_FXP_DECIMAL_BITS 10
`endif

module exp_taylor #(
    parameter int N_TERMS   = 8,
    parameter int FRAC_BITS = `H_FXP_DECIMAL_BITS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    if (N_TERMS < 1 || N_TERMS > 15) begin : g_bad_terms
        $error("exp_taylor: N_TERMS must be in 1..15");
    end

    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [31:0] x_reg;
    logic signed [31:0] acc;
    logic        [3:0]  k;

    logic signed [63:0] p;
    logic signed [31:0] t;
    logic signed [31:0] divisor;
    logic signed [31:0] quot;

    // Full-width product, then floor-shift back to the fixed-point scale.
    always_comb begin
        p       = 64'(acc) * 64'(x_reg);
        t       = 32'(p >>> FRAC_BITS);
        // k is only zero outside CALC where quot is unused; keep the divider defined.
        divisor = (k == 4'd0) ? 32'sd1 : $signed({28'd0, k});
        quot    = t / divisor;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (k == 4'd1) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_data;
                        acc   <= ONE;
                        k     <= 4'(N_TERMS);
                    end
                end
                CALC: begin
                    acc <= ONE + quot;
                    k   <= k - 4'd1;
                    // Last term divides by 1, so the result is ONE + t directly.
                    if (k == 4'd1) begin
                        out_data  <= ONE + t;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_taylor.sv
module tb_exp_taylor;

    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_data, out_data;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [31:0] in_data1, out_data1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_q[$];
    int acc_q[$];
    int pend_exp;
    bit inflight;
    bit prev_valid;

    exp_taylor #(.N_TERMS(N), .FRAC_BITS(10)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    exp_taylor #(.N_TERMS(1), .FRAC_BITS(10)) dut1 (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: Horner evaluation straight from the series definition.
    function automatic int model(int x, int n);
        int     a = 1024;
        longint pr;
        int     tt;
        for (int kk = n; kk >= 1; kk--) begin
            pr = longint'(a) * longint'(x);
            tt = int'(pr >>> 10);
            if (kk == 1) return 1024 + tt;
            a = 1024 + tt / kk;
        end
        return 0;
    endfunction

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK or posedge RST);
            if (RST) begin
                exp_q.delete();
                acc_q.delete();
                inflight   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                chk("in_ready", int'(in_ready), int'(!inflight));
                chk("busy", int'(busy), int'(inflight));
                if (out_valid && !prev_valid) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL valid_without_accept: out_valid rose with no accepted argument");
                    end else begin
                        chk("latency", cyc - acc_q.pop_front(), N);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0d with empty scoreboard", $signed(out_data));
                    end else begin
                        chk("result", $signed(out_data), exp_q.pop_front());
                    end
                    inflight = 1'b0;
                end else if (out_valid && exp_q.size() > 0) begin
                    chk("held_result", $signed(out_data), exp_q[0]);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(pend_exp);
                    acc_q.push_back(cyc + 1);
                    inflight = 1'b1;
                end
                prev_valid = out_valid;
            end
        end
    endtask

    task automatic send(input int x, input int e, input bit hold, output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc  = -1;
        pend_exp = e;
        in_data  = x;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                acc_cyc = cyc + 1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: x=%0d never accepted", x);
        end
        @(posedge CLK);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: out_valid never rose");
        end
    endtask

    task automatic wait_out(input int delay);
        wait_valid();
        repeat (delay) begin
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int a0, a1, a2, x;
        int xs[3];
        int es[3];

        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        pend_exp   = 0;
        inflight   = 1'b0;
        prev_valid = 1'b0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // x = 1.0
        send(1024, 2783, 1'b0, a0);
        wait_out(0);
        chk("data_kept_after_hs", int'(out_data), 2783);

        xs = '{-1024, 512, 0};
        es = '{377, 1688, 1024};
        foreach (xs[i]) begin
            send(xs[i], es[i], 1'b0, a0);
            wait_out(1);
        end

        // Back-pressure with an ignored in_valid pulse while DONE.
        send(1024, 2783, 1'b0, a0);
        wait_valid();
        pend_exp = 0;
        in_data  = 777;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_out_data", int'(out_data), 2783);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        send(512, 1688, 1'b0, a0);
        wait_out(0);

        // Asynchronous reset between edges of iteration 4.
        send(1024, 2783, 1'b0, a0);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_busy", int'(busy), 0);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        send(1024, 2783, 1'b0, a0);
        wait_out(0);

        // Streaming with in_valid and out_ready held high.
        out_ready = 1'b1;
        send(1024, 2783, 1'b1, a0);
        send(-1024, 377, 1'b1, a1);
        send(512, 1688, 1'b0, a2);
        chk("stream_gap1", a1 - a0, N + 2);
        chk("stream_gap2", a2 - a1, N + 2);
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        out_ready = 1'b0;

        // Single-term instance: ONE + x after one CALC cycle.
        in_data1  = 32'd1024;
        in_valid1 = 1'b1;
        @(posedge CLK);
        #1;
        in_valid1 = 1'b0;
        chk("n1_busy", int'(busy1), 1);
        chk("n1_valid_early", int'(out_valid1), 0);
        @(posedge CLK);
        #1;
        chk("n1_valid", int'(out_valid1), 1);
        chk("n1_data", int'(out_data1), 2048);
        out_ready1 = 1'b1;
        @(posedge CLK);
        #1;
        out_ready1 = 1'b0;
        chk("n1_in_ready", int'(in_ready1), 1);

        // Range endpoints and random arguments against the reference.
        send(8192, model(8192, N), 1'b0, a0);
        wait_out(0);
        send(-8192, model(-8192, N), 1'b0, a0);
        wait_out(2);
        for (int i = 0; i < 16; i++) begin
            x = int'($urandom_range(16384)) - 8192;
            send(x, model(x, N), 1'b0, a0);
            wait_out(int'($urandom_range(3)));
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
